// File: rtl/rr_reg_arbiter_if.sv
// rr_reg_arbiter_if: requester-side bus of the shared-register arbiter.
// Ports: req/lock/wdata from requesters; gnt/owner/q/upd back to them.
interface rr_reg_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [OW-1:0]         owner;
    logic [WIDTH-1:0]      q;
    logic                  upd;

    // requester side
    modport master (
        output req, lock, wdata,
        input  gnt, owner, q, upd
    );

    // arbiter side
    modport slave (
        input  req, lock, wdata,
        output gnt, owner, q, upd
    );
endinterface

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin write arbiter owning one shared register.
// Ports: clk, rst (async active-low), bus (slave: req/lock/wdata in; gnt/owner/q/upd out).
module rr_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic            clk,
    input  logic            rst,
    rr_reg_arbiter_if.slave bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_LOCK
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     w_owner_nxt;
    logic [7:0]        r_lock_cnt;
    logic [7:0]        w_lock_cnt_nxt;
    logic [WIDTH-1:0]  r_q;
    logic              r_upd;

    logic              w_cont;
    logic              w_found;
    logic [OW-1:0]     w_win;
    logic [OW-1:0]     w_idx;
    logic [WIDTH-1:0]  w_wsel;

    // A running burst keeps the grant while the owner still asks for it.
    assign w_cont = (r_state == S_LOCK)
                 && bus.req[r_owner]
                 && bus.lock[r_owner]
                 && (r_lock_cnt < 8'(MAX_LOCK));

    // Search owner+1 .. owner+NREQ; the last slot is the current owner,
    // which is skipped whenever it held the grant this cycle.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_owner;
        w_idx   = r_owner;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = OW'((int'(r_owner) + k) % NREQ);
            if (!w_found && bus.req[w_idx]
                && !(k == NREQ && r_state != S_IDLE)) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_cont) begin
            w_lock_cnt_nxt = r_lock_cnt + 8'd1;
        end else if (w_found) begin
            w_gnt_nxt        = '0;
            w_gnt_nxt[w_win] = 1'b1;
            w_owner_nxt      = w_win;
            w_lock_cnt_nxt   = 8'd1;
            w_state_nxt      = bus.lock[w_win] ? S_LOCK : S_GRANT;
        end else begin
            w_gnt_nxt   = '0;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_owner    <= OW'(NREQ - 1);
            r_lock_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Data of the current grantee; owner equals the grantee while gnt != 0.
    assign w_wsel = bus.wdata[r_owner*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= '0;
            r_upd <= 1'b0;
        end else if (r_gnt != '0) begin
            r_q   <= w_wsel;
            r_upd <= 1'b1;
        end else begin
            r_upd <= 1'b0;
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.owner = r_owner;
    assign bus.q     = r_q;
    assign bus.upd   = r_upd;
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter: directed and random checks of rr_reg_arbiter
// against a behavioural grant/burst model.
module tb_rr_reg_arbiter;
    localparam int WIDTH    = 8;
    localparam int NREQ     = 4;
    localparam int MAX_LOCK = 4;
    localparam int BOUND    = (NREQ - 1) * (MAX_LOCK + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    rr_reg_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    rr_reg_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // model: grantee index (-1 none), last grantee, burst state, register
    int               m_gnt;
    int               m_owner;
    int               m_burst;
    bit               m_locked;
    logic [WIDTH-1:0] m_q;
    logic             m_upd;
    int               wait_c[NREQ];
    logic [NREQ-1:0]  prev_req;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt    = -1;
        m_owner  = NREQ - 1;
        m_burst  = 0;
        m_locked = 0;
        m_q      = '0;
        m_upd    = 1'b0;
        for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
    endtask

    task automatic model_step();
        int win;
        bit cont;
        if (m_gnt >= 0) begin
            m_q   = bus.wdata[m_gnt*WIDTH +: WIDTH];
            m_upd = 1'b1;
        end else begin
            m_upd = 1'b0;
        end
        cont = (m_gnt >= 0) && m_locked && bus.req[m_gnt]
            && bus.lock[m_gnt] && (m_burst < MAX_LOCK);
        if (cont) begin
            m_burst++;
        end else begin
            win = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int c = (m_owner + k) % NREQ;
                if (win < 0 && c != m_gnt && bus.req[c]) win = c;
            end
            if (win >= 0) begin
                m_gnt    = win;
                m_owner  = win;
                m_locked = bus.lock[win];
                m_burst  = 1;
            end else begin
                m_gnt    = -1;
                m_locked = 0;
            end
        end
    endtask

    function automatic logic [NREQ-1:0] exp_gnt();
        logic [NREQ-1:0] v = '0;
        if (m_gnt >= 0) v[m_gnt] = 1'b1;
        return v;
    endfunction

    task automatic check_model(string pfx);
        chk({pfx, "_gnt"},   bus.gnt,   exp_gnt());
        chk({pfx, "_owner"}, bus.owner, m_owner);
        chk({pfx, "_q"},     bus.q,     m_q);
        chk({pfx, "_upd"},   bus.upd,   m_upd);
    endtask

    // one clock: step model at the edge, compare 1 time unit later
    task automatic cycle();
        prev_req = bus.req;
        @(posedge clk);
        if (rst) model_step();
        #1;
        check_model("cyc");
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) begin
                chk("starve", 32'(wait_c[i] < BOUND), 1);
                wait_c[i] = 0;
            end else if (prev_req[i]) begin
                wait_c[i]++;
            end else begin
                wait_c[i] = 0;
            end
        end
    endtask

    // entered 1 unit after a posedge; reset acts between edges
    task automatic do_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_model("rst_now");
        chk("rst_owner_c", bus.owner, NREQ - 1);
        @(posedge clk);
        #1;
        check_model("rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        bus.req   = '0;
        bus.lock  = '0;
        bus.wdata = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_model("init");
        rst = 1'b1;

        // reset while a grant is up, then idle after release
        bus.req = 4'b0100;
        cycle();
        chk("pre_rst_gnt", bus.gnt, 4'b0100);
        bus.req = '0;
        do_reset();
        chk("rst_gnt", bus.gnt, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("idle_gnt", bus.gnt, 0);
            chk("idle_owner", bus.owner, NREQ - 1);
        end

        // lone requester: granted every other cycle
        bus.req   = 4'b0001;
        bus.wdata = 32'h000000A5;
        cycle();
        chk("single_g1", bus.gnt, 4'b0001);
        cycle();
        chk("single_q", bus.q, 8'hA5);
        chk("single_upd", bus.upd, 1);
        chk("single_g2", bus.gnt, 0);
        cycle();
        chk("single_g3", bus.gnt, 4'b0001);
        bus.req = '0;
        do_reset();

        // full contention rotates 0,1,2,3,0
        bus.req   = 4'b1111;
        bus.wdata = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_gnt", bus.gnt, 32'(1) << (k % 4));
            if (k > 0) chk("rr_q", bus.q, 32'h10 + k - 1);
        end
        bus.req = '0;
        do_reset();

        // lock capped at MAX_LOCK, hand-over without gap
        bus.req  = 4'b0110;
        bus.lock = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            if (k <= 4) chk("cap_gnt", bus.gnt, 4'b0010);
            if (k == 5) chk("cap_next", bus.gnt, 4'b0100);
            if (k >= 2) chk("cap_upd", bus.upd, 1);
        end
        bus.req  = '0;
        bus.lock = '0;
        do_reset();

        // early lock release goes to requester 3 first
        bus.req  = 4'b1010;
        bus.lock = 4'b0010;
        cycle();
        chk("early_1", bus.gnt, 4'b0010);
        cycle();
        chk("early_2", bus.gnt, 4'b0010);
        bus.lock = '0;
        cycle();
        chk("early_3", bus.gnt, 4'b1000);
        bus.req = '0;
        do_reset();

        // reset during the 3rd burst cycle
        bus.req  = 4'b0110;
        bus.lock = 4'b0010;
        bus.wdata = 32'h44332211;
        for (int k = 0; k < 3; k++) cycle();
        chk("mid_gnt_pre", bus.gnt, 4'b0010);
        do_reset();
        chk("mid_q", bus.q, 0);
        cycle();
        chk("mid_first", bus.gnt, 4'b0010);
        bus.req  = '0;
        bus.lock = '0;
        cycle();

        // random traffic with sticky requests and rare resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0) bus.req[i] = ~bus.req[i];
                if ($urandom_range(0, 3) == 0) bus.lock[i] = $urandom_range(0, 2) != 0;
                bus.wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
